// File: rtl/mem_lsu_pkg.sv
// Shared encodings and the request legality check for the mem load/store unit.
package mem_lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int MEM_BYTES_DEFAULT = 1372;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // mem always moves 4 bytes, so the last legal start address is mem_bytes-4.
    function automatic logic req_illegal(input logic [1:0] size, input logic [31:0] addr,
                                         input int mem_bytes);
        return (size == SIZE_H && addr[0])
            || (size == SIZE_W && addr[1:0] != 2'b00)
            || (size == 2'b11)
            || (addr > 32'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Load byte/half extraction with sign or zero extension, and sub-word store lane merge.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data = word;
        case (size)
            SIZE_B:  load_data = {{24{sext & word[7]}}, word[7:0]};
            SIZE_H:  load_data = {{16{sext & word[15]}}, word[15:0]};
            default: load_data = word;
        endcase
    end

    // The untouched upper lanes come from the word just read back from mem.
    always_comb begin
        merge_data = store_data;
        case (size)
            SIZE_B:  merge_data = {word[31:8], store_data[7:0]};
            SIZE_H:  merge_data = {word[31:16], store_data[15:0]};
            default: merge_data = store_data;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: turns one CPU request into mem read/write port activity,
// using read-modify-write for sub-word stores. Every output is a register.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_memwr,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  fsm_state
);

    // Handshake: a request transfers on a posedge where req=1 and ready=1; ready is
    // high only in IDLE, so the requester holds req until it sees ready.
    state_t      state, state_nx;
    logic        accept, illegal;
    logic        lat_we, lat_sext;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] load_data, merge_data;
    logic        ready_d, done_d, err_d, memwr_d;
    logic [31:0] rdata_d, raddr_d, waddr_d, wdata_d;

    assign accept    = req & ready;
    assign illegal   = req_illegal(size, addr, MEM_BYTES);
    assign fsm_state = state;

    mem_lsu_align u_align (
        .size       (lat_size),
        .sext       (lat_sext),
        .word       (mem_rdata),
        .store_data (lat_wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal)                    state_nx = ST_DONE;
                    else if (!we || size != SIZE_W) state_nx = ST_RD;
                    else                            state_nx = ST_WR;
                end
            end
            ST_RD:   state_nx = lat_we ? ST_WR : ST_DONE;
            ST_WR:   state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; address/data registers hold when idle.
    always_comb begin
        ready_d = (state_nx == ST_IDLE);
        done_d  = (state_nx == ST_DONE);
        err_d   = (state == ST_IDLE) && accept && illegal;
        memwr_d = (state_nx == ST_WR);
        rdata_d = rdata;
        raddr_d = mem_raddr;
        waddr_d = mem_waddr;
        wdata_d = mem_wdata;
        case (state)
            ST_IDLE: begin
                if (state_nx == ST_RD) raddr_d = addr;
                if (state_nx == ST_WR) begin
                    waddr_d = addr;
                    wdata_d = wdata;
                end
            end
            ST_RD: begin
                if (lat_we) begin
                    waddr_d = lat_addr;
                    wdata_d = merge_data;
                end else begin
                    rdata_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_memwr <= 1'b0;
        end else begin
            ready     <= ready_d;
            done      <= done_d;
            err       <= err_d;
            rdata     <= rdata_d;
            mem_raddr <= raddr_d;
            mem_waddr <= waddr_d;
            mem_wdata <= wdata_d;
            mem_memwr <= memwr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_sext  <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == ST_IDLE && accept) begin
            lat_we    <= we;
            lat_sext  <= sext;
            lat_size  <= size;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu with a byte-addressed little-endian mem model on the negedge.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int MB = 1372;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, sext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, done, err, mem_memwr;
    logic [31:0] rdata, mem_raddr, mem_waddr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  fsm_state;

    typedef struct packed {
        logic        err;
        logic        chk_rd;
        logic [31:0] rdata;
        logic [7:0]  lat;
        logic [7:0]  wr;
        logic [31:0] acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem_b [0:MB-1];
    int         cyc = 0;
    int         wr_cnt = 0;
    int         n_tests = 0, n_fail = 0;

    mem_lsu #(.MEM_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_memwr(mem_memwr), .mem_rdata(mem_rdata),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- mem model ----------------
    function automatic logic [7:0] rd_byte(input int a);
        if (a >= 0 && a < MB) return mem_b[a];
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        if (mem_memwr)
            for (int i = 0; i < 4; i++)
                if (int'(mem_waddr) + i < MB) mem_b[int'(mem_waddr) + i] = mem_wdata[8*i +: 8];
        mem_rdata = {rd_byte(int'(mem_raddr) + 3), rd_byte(int'(mem_raddr) + 2),
                     rd_byte(int'(mem_raddr) + 1), rd_byte(int'(mem_raddr))};
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            wr_cnt = 0;
        end else begin
            if (mem_memwr) wr_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    if (e.chk_rd) chk("rdata", rdata, e.rdata);
                    chk("latency", 32'(cyc) - e.acc + 32'd1, 32'(e.lat));
                    chk("memwr_cycles", 32'(wr_cnt), 32'(e.wr));
                end
                wr_cnt = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we_i, input logic [1:0] size_i, input logic sext_i,
                         input logic [31:0] addr_i, input logic [31:0] wdata_i,
                         input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                         input int exp_lat, input int exp_wr, output int acc);
        int waits;
        exp_t e;
        waits = 0;
        acc = 0;
        @(negedge clk);
        req = 1'b1; we = we_i; size = size_i; sext = sext_i; addr = addr_i; wdata = wdata_i;
        while (!ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!ready) begin
            chk("accept_timeout", 32'(ready), 32'd1);
            req = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd;
            e.lat = 8'(exp_lat); e.wr = 8'(exp_wr); e.acc = 32'(acc);
            exp_q.push_back(e);
            req = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc_a, acc_b, waits;
        for (int i = 0; i < MB; i++) mem_b[i] = 8'(i);
        mem_b[8] = 8'h34; mem_b[9] = 8'h12; mem_b[10] = 8'hFF; mem_b[11] = 8'h80;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {28'd0, ready, done, err, mem_memwr}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", 32'(ready), 32'd1);

        // loads of the preloaded word
        issue(1'b0, SIZE_W, 1'b0, 32'd8,  '0, 1'b0, 1'b1, 32'h80FF1234, 2, 0, acc_a);
        issue(1'b0, SIZE_B, 1'b1, 32'd8,  '0, 1'b0, 1'b1, 32'h00000034, 2, 0, acc_a);
        issue(1'b0, SIZE_H, 1'b1, 32'd10, '0, 1'b0, 1'b1, 32'hFFFF80FF, 2, 0, acc_a);
        issue(1'b0, SIZE_H, 1'b0, 32'd10, '0, 1'b0, 1'b1, 32'h000080FF, 2, 0, acc_a);
        issue(1'b0, SIZE_B, 1'b1, 32'd11, '0, 1'b0, 1'b1, 32'hFFFFFF80, 2, 0, acc_a);
        issue(1'b0, SIZE_B, 1'b0, 32'd11, '0, 1'b0, 1'b1, 32'h00000080, 2, 0, acc_a);

        // byte store via read-modify-write; rdata must be left alone
        issue(1'b1, SIZE_B, 1'b0, 32'd8, 32'hAAAAAA5A, 1'b0, 1'b1, 32'h00000080, 3, 1, acc_a);
        issue(1'b0, SIZE_W, 1'b0, 32'd8, '0, 1'b0, 1'b1, 32'h80FF125A, 2, 0, acc_a);

        // illegal requests and range boundary
        issue(1'b1, SIZE_H, 1'b0, 32'd9,    32'h1234, 1'b1, 1'b0, '0, 1, 0, acc_a);
        issue(1'b0, SIZE_W, 1'b0, 32'd1369, '0, 1'b1, 1'b0, '0, 1, 0, acc_a);
        issue(1'b0, SIZE_W, 1'b0, 32'd1368, '0, 1'b0, 1'b1, 32'h5B5A5958, 2, 0, acc_a);
        issue(1'b0, 2'b11,  1'b0, 32'd0,    '0, 1'b1, 1'b0, '0, 1, 0, acc_a);
        issue(1'b1, SIZE_W, 1'b0, 32'd14,   32'h0, 1'b1, 1'b0, '0, 1, 0, acc_a);
        issue(1'b0, SIZE_H, 1'b0, 32'h80000000, '0, 1'b1, 1'b0, '0, 1, 0, acc_a);

        // back-to-back SW then SB with req held, then halfword RMW
        issue(1'b1, SIZE_W, 1'b0, 32'd12, 32'hDEADBEEF, 1'b0, 1'b1, 32'h5B5A5958, 2, 1, acc_a);
        issue(1'b1, SIZE_B, 1'b0, 32'd12, 32'h00000077, 1'b0, 1'b1, 32'h5B5A5958, 3, 1, acc_b);
        chk("accept_gap", 32'(acc_b - acc_a), 32'd3);
        issue(1'b0, SIZE_W, 1'b0, 32'd12, '0, 1'b0, 1'b1, 32'hDEADBE77, 2, 0, acc_a);
        issue(1'b1, SIZE_H, 1'b0, 32'd14, 32'h5555CAFE, 1'b0, 1'b1, 32'hDEADBE77, 3, 1, acc_a);
        issue(1'b0, SIZE_W, 1'b0, 32'd12, '0, 1'b0, 1'b1, 32'hCAFEBE77, 2, 0, acc_a);

        // reset while in WR, before the mid-cycle write
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = SIZE_W; sext = 1'b0; addr = 32'd16; wdata = 32'h11111111;
        waits = 0;
        while (!ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk("accept_before_reset", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("in_wr_state", 32'(fsm_state), 32'(ST_WR));
        chk("memwr_in_wr", 32'(mem_memwr), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_flags", {28'd0, ready, done, err, mem_memwr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_ports", mem_raddr | mem_waddr | mem_wdata, 32'd0);
        chk("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        #1;
        chk("mem_16_kept", {mem_b[19], mem_b[18], mem_b[17], mem_b[16]}, 32'h13121110);
        rst = 1'b0;
        waits = 0;
        while (!ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        chk("ready_after_abort", 32'(ready), 32'd1);

        issue(1'b0, SIZE_W, 1'b0, 32'd16, '0, 1'b0, 1'b1, 32'h13121110, 2, 0, acc_a);

        waits = 0;
        while (exp_q.size() > 0 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
